// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the operand-select pipeline muxes: state encoding,
// default register-index width and the select range check.
package cpu_mux_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [STATE_W-1:0] EMPTY = 2'd0;
    localparam logic [STATE_W-1:0] ONE   = 2'd1;
    localparam logic [STATE_W-1:0] FULL  = 2'd2;

    // Unsigned compare of an operand index against the operand count.
    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n_in);
        return sel < n_in;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N:1 operand select with out-of-range flag; an out-of-range
// index yields all-zero data.
module mux_n_comb
    import cpu_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = REG_IDX_W,
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      sel_data_c,
    output logic                  sel_err_c
);

    always_comb begin
        sel_data_c = '0;
        sel_err_c  = !sel_in_range(32'(sel), N_IN);
        for (int k = 0; k < int'(N_IN); k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data_c = data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 operand select registered into a 2-entry skid buffer (valid/ready, flush).
// Optional stored even parity output enabled by MUX_N_PIPE_PARITY_EN.
module mux_n_pipe
    import cpu_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = REG_IDX_W,
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_sel_err,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_N_PIPE_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    logic             accept_c;
    logic             consume_c;
    logic             load_main_new_c;
    logic             load_main_skid_c;
    logic             load_skid_c;
    logic [WIDTH-1:0] new_data_c;
    logic             new_err_c;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_err_q;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_sel (
        .data       (in_data),
        .sel        (in_sel),
        .sel_data_c (new_data_c),
        .sel_err_c  (new_err_c)
    );

    assign accept_c  = in_valid & in_ready;
    assign consume_c = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; flush wins over any same-cycle accept
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept_c) state_d = ONE;
                ONE: begin
                    if (accept_c && !consume_c)      state_d = FULL;
                    else if (!accept_c && consume_c) state_d = EMPTY;
                end
                FULL:    if (consume_c) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Entry load enables; a flushed cycle writes nothing
    always_comb begin
        load_main_new_c  = 1'b0;
        load_main_skid_c = 1'b0;
        load_skid_c      = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: load_main_new_c = accept_c;
                ONE: begin
                    load_main_new_c = accept_c & consume_c;
                    load_skid_c     = accept_c & !consume_c;
                end
                FULL:    load_main_skid_c = consume_c;
                default: ;
            endcase
        end
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
        end
    end

    // Entry data registers, written only on accept or skid-to-main shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_sel_err <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            if (load_main_new_c) begin
                out_data    <= new_data_c;
                out_sel_err <= new_err_c;
            end else if (load_main_skid_c) begin
                out_data    <= skid_data_q;
                out_sel_err <= skid_err_q;
            end
            if (load_skid_c) begin
                skid_data_q <= new_data_c;
                skid_err_q  <= new_err_c;
            end
        end
    end

`ifdef MUX_N_PIPE_PARITY_EN
    logic new_par_c;
    logic skid_par_q;

    // Out-of-range entries carry zero data, hence zero parity
    assign new_par_c = ^new_data_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            if (load_main_new_c)       out_parity <= new_par_c;
            else if (load_main_skid_c) out_parity <= skid_par_q;
            if (load_skid_c)           skid_par_q <= new_par_c;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: scoreboard on a 4-input instance plus
// direct checks on a 3-input instance for the out-of-range select.
module tb_mux_n_pipe;

    typedef struct packed {
        logic       par;
        logic       err;
        logic [4:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [19:0] in_data4;
    logic [1:0]  sel4;
    logic        iv4, ir4, fl4, ov4, or4, oe4;
    logic [4:0]  od4;

    logic [14:0] in_data3;
    logic [1:0]  sel3;
    logic        iv3, ir3, fl3, ov3, or3, oe3;
    logic [4:0]  od3;

`ifdef MUX_N_PIPE_PARITY_EN
    logic        op4, op3;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    mux_n_pipe #(.WIDTH(5), .N_IN(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data4),
        .in_sel      (sel4),
        .in_valid    (iv4),
        .in_ready    (ir4),
        .flush       (fl4),
        .out_data    (od4),
        .out_sel_err (oe4),
        .out_valid   (ov4),
        .out_ready   (or4)
`ifdef MUX_N_PIPE_PARITY_EN
        ,
        .out_parity  (op4)
`endif
    );

    mux_n_pipe #(.WIDTH(5), .N_IN(3)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data3),
        .in_sel      (sel3),
        .in_valid    (iv3),
        .in_ready    (ir3),
        .flush       (fl3),
        .out_data    (od3),
        .out_sel_err (oe3),
        .out_valid   (ov3),
        .out_ready   (or3)
`ifdef MUX_N_PIPE_PARITY_EN
        ,
        .out_parity  (op3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model4(input logic [19:0] d, input logic [1:0] s);
        exp_t e;
        logic [19:0] sh;
        sh     = d >> (5 * int'(s));
        e.err  = (int'(s) >= 4);
        e.data = e.err ? 5'd0 : sh[4:0];
        e.par  = ^e.data;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = ir4;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(ok), 1);
    endtask

    // Scoreboard: a consume seen at the falling edge completes at the next rising edge
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (ov4 && or4) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'(q.size()), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_data", 32'(od4), 32'(e.data));
                    chk("sb_err", 32'(oe4), 32'(e.err));
`ifdef MUX_N_PIPE_PARITY_EN
                    chk("sb_par", 32'(op4), 32'(e.par));
`endif
                end
            end
            if (fl4) q.delete();
            else if (iv4 && ir4) q.push_back(model4(in_data4, sel4));
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_data4 = {5'd3, 5'd17, 5'd9, 5'd30};
        sel4 = 2'd0; iv4 = 1'b0; fl4 = 1'b0; or4 = 1'b1;
        in_data3 = {5'd7, 5'd12, 5'd21};
        sel3 = 2'd0; iv3 = 1'b0; fl3 = 1'b0; or3 = 1'b1;

        // Reset values
        #2;
        chk("rst_valid", 32'(ov4), 0);
        chk("rst_ready", 32'(ir4), 0);
        chk("rst_data", 32'(od4), 0);
        chk("rst_err", 32'(oe4), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("ready_before_edge", 32'(ir4), 0);
        tick();
        chk("ready_after_edge", 32'(ir4), 1);
        chk("ready_after_edge3", 32'(ir3), 1);
        chk("idle_valid", 32'(ov4), 0);

        // Single transfer
        iv4 = 1'b1; sel4 = 2'd2;
        tick();
        iv4 = 1'b0;
        chk("single_valid", 32'(ov4), 1);
        chk("single_data", 32'(od4), 17);
        chk("single_err", 32'(oe4), 0);
        tick();
        chk("single_drain", 32'(ov4), 0);

        // Full throughput with out_ready held high
        iv4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            tick();
            chk("tput_ready", 32'(ir4), 1);
            chk("tput_valid", 32'(ov4), 1);
        end
        iv4 = 1'b0;
        tick();
        chk("tput_drain", 32'(ov4), 0);

        // Back-pressure: two words fit, third is held upstream
        or4 = 1'b0;
        iv4 = 1'b1; sel4 = 2'd0;
        tick();
        chk("bp_ready_one", 32'(ir4), 1);
        sel4 = 2'd1;
        tick();
        chk("bp_ready_full", 32'(ir4), 0);
        sel4 = 2'd3;
        tick();
        tick();
        chk("bp_hold_ready", 32'(ir4), 0);
        chk("bp_hold_valid", 32'(ov4), 1);
        chk("bp_hold_data", 32'(od4), 30);
        or4 = 1'b1;
        wait_accept();
        iv4 = 1'b0;
        tick();
        tick();
        chk("bp_drain", 32'(ov4), 0);

        // Out-of-range select on the 3-input instance
        iv3 = 1'b1; sel3 = 2'd3;
        tick();
        chk("selerr_valid", 32'(ov3), 1);
        chk("selerr_data", 32'(od3), 0);
        chk("selerr_flag", 32'(oe3), 1);
        sel3 = 2'd0;
        tick();
        iv3 = 1'b0;
        chk("selok_data", 32'(od3), 21);
        chk("selok_flag", 32'(oe3), 0);
        tick();
        chk("sel3_drain", 32'(ov3), 0);

        // Flush while FULL with a same-cycle consume
        or4 = 1'b0;
        iv4 = 1'b1; sel4 = 2'd2;
        tick();
        sel4 = 2'd3;
        tick();
        iv4 = 1'b0;
        chk("fl_full_ready", 32'(ir4), 0);
        fl4 = 1'b1; or4 = 1'b1;
        tick();
        fl4 = 1'b0;
        chk("fl_valid", 32'(ov4), 0);
        chk("fl_ready", 32'(ir4), 1);
        tick();
        chk("fl_skid_gone", 32'(ov4), 0);

        // Flush in EMPTY drops the offered word
        fl4 = 1'b1; iv4 = 1'b1; sel4 = 2'd1;
        tick();
        fl4 = 1'b0; iv4 = 1'b0;
        chk("fl_drop_valid", 32'(ov4), 0);
        tick();
        chk("fl_drop_valid2", 32'(ov4), 0);

        // Asynchronous reset while FULL
        or4 = 1'b0;
        iv4 = 1'b1; sel4 = 2'd1;
        tick();
        sel4 = 2'd2;
        tick();
        iv4 = 1'b0;
        chk("pre_rst_valid", 32'(ov4), 1);
        chk("pre_rst_data", 32'(od4), 9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov4), 0);
        chk("arst_data", 32'(od4), 0);
        chk("arst_ready", 32'(ir4), 0);
        tick();
        rst_n = 1'b1;
        chk("arst_rel_ready", 32'(ir4), 0);
        tick();
        chk("arst_rel_ready2", 32'(ir4), 1);
        chk("arst_rel_valid", 32'(ov4), 0);
        or4 = 1'b1;

`ifdef MUX_N_PIPE_PARITY_EN
        in_data4 = {5'd3, 5'b10110, 5'b10010, 5'd30};
        iv4 = 1'b1; sel4 = 2'd2;
        tick();
        iv4 = 1'b0;
        chk("par_odd_data", 32'(od4), 32'(5'b10110));
        chk("par_odd", 32'(op4), 1);
        tick();
        iv4 = 1'b1; sel4 = 2'd1;
        tick();
        iv4 = 1'b0;
        chk("par_even_data", 32'(od4), 32'(5'b10010));
        chk("par_even", 32'(op4), 0);
        tick();
`endif

        tick();
        chk("sb_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
